// File: rtl/cam_cfg_pkg.sv
// ============================================================================
// cam_cfg_pkg : shared op encodings, table-entry field helpers and FSM states
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cam_cfg_pkg;

  localparam int ENTRY_W = 26;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_VFY = 2'b01,
    OP_DLY = 2'b10,
    OP_END = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PWR_WAIT = 4'd1,
    ST_FETCH    = 4'd2,
    ST_DECODE   = 4'd3,
    ST_ISSUE    = 4'd4,
    ST_WAIT_I2C = 4'd5,
    ST_WAIT_DLY = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8
  } state_t;

  function automatic op_t entry_op(input logic [ENTRY_W-1:0] e);
    return op_t'(e[25:24]);
  endfunction

  function automatic logic [15:0] entry_addr(input logic [ENTRY_W-1:0] e);
    return e[23:8];
  endfunction

  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_delay_timer.sv
// ============================================================================
// cfg_delay_timer : loadable down-counter, expired while the count sits at 0
// Revision        : 1.0
// ============================================================================
`default_nettype none

module cfg_delay_timer #(
  parameter int W       = 16,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Reset value lets the power-up wait run straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/sccb_cfg_sequencer.sv
// ============================================================================
// sccb_cfg_sequencer : walks a {op, reg_addr, data} table and drives i2c_dri
// Revision           : 1.0
// ============================================================================
`default_nettype none

module sccb_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int TBL_AW    = 8,
  parameter int PWR_DLY   = 5000,
  parameter int DLY_UNIT  = 1000,
  parameter int MAX_RETRY = 3,
  parameter int ADDR16    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [25:0]       tbl_entry,
  output logic              i2c_exec,
  output logic              i2c_rh_wl,
  output logic              i2c_bit_ctrl,
  output logic [23:0]       i2c_data,
  input  logic              i2c_done,
  input  logic              i2c_ack,
  input  logic [7:0]        i2c_data_r,
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int DLY_MAX = 255 * DLY_UNIT;
  localparam int TMR_MAX = (PWR_DLY > DLY_MAX) ? PWR_DLY : DLY_MAX;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  op_t               op_q, op_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        retry_q, retry_d;
  logic              exec_q, exec_d;
  logic              rh_wl_q, rh_wl_d;
  logic [23:0]       i2c_data_q, i2c_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_expired;
  logic [31:0]       dly_cycles;
  logic              last_entry;
  logic              xfer_ok;
  op_t               ent_op;

  assign ent_op     = entry_op(tbl_entry);
  assign dly_cycles = 32'(entry_data(tbl_entry)) * 32'(DLY_UNIT);
  assign last_entry = (tbl_addr_q == {TBL_AW{1'b1}});
  assign xfer_ok    = !i2c_ack && ((op_q == OP_WR) || (i2c_data_r == data_q));

  cfg_delay_timer #(
    .W       (TMR_W),
    .RST_VAL (PWR_DLY - 1)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    tbl_addr_d = tbl_addr_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    retry_d    = retry_q;
    exec_d     = 1'b0;
    rh_wl_d    = rh_wl_q;
    i2c_data_d = i2c_data_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    tmr_load   = 1'b0;
    tmr_val    = TMR_W'(PWR_DLY - 1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          tbl_addr_d = '0;
          retry_d    = '0;
          tmr_load   = 1'b1;
          state_d    = ST_PWR_WAIT;
        end
      end
      ST_PWR_WAIT: begin
        if (tmr_expired) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d   = ent_op;
        addr_d = entry_addr(tbl_entry);
        data_d = entry_data(tbl_entry);
        case (ent_op)
          OP_WR, OP_VFY: state_d = ST_ISSUE;
          OP_DLY: begin
            // A zero delay still spends one cycle in WAIT_DLY.
            tmr_load = 1'b1;
            tmr_val  = (entry_data(tbl_entry) == 8'h00) ? '0 : TMR_W'(dly_cycles - 32'd1);
            state_d  = ST_WAIT_DLY;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_ISSUE: begin
        exec_d     = 1'b1;
        rh_wl_d    = (op_q == OP_VFY);
        i2c_data_d = {((ADDR16 != 0) ? addr_q : {8'h00, addr_q[7:0]}), data_q};
        state_d    = ST_WAIT_I2C;
      end
      ST_WAIT_I2C: begin
        if (i2c_done) begin
          if (xfer_ok) begin
            retry_d = '0;
            if (last_entry) begin
              state_d = ST_DONE;
            end else begin
              tbl_addr_d = tbl_addr_q + 1'b1;
              state_d    = ST_FETCH;
            end
          end else if (retry_q < 8'(MAX_RETRY)) begin
            retry_d = retry_q + 8'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_WAIT_DLY: begin
        if (tmr_expired) begin
          if (last_entry) begin
            state_d = ST_DONE;
          end else begin
            tbl_addr_d = tbl_addr_q + 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d     = 1'b1;
        err_idx_d = tbl_addr_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset lands in PWR_WAIT so the sequence auto-starts once rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PWR_WAIT;
      tbl_addr_q <= '0;
      op_q       <= OP_WR;
      addr_q     <= '0;
      data_q     <= '0;
      retry_q    <= '0;
      exec_q     <= 1'b0;
      rh_wl_q    <= 1'b0;
      i2c_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      tbl_addr_q <= tbl_addr_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      retry_q    <= retry_d;
      exec_q     <= exec_d;
      rh_wl_q    <= rh_wl_d;
      i2c_data_q <= i2c_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign tbl_addr     = tbl_addr_q;
  assign i2c_exec     = exec_q;
  assign i2c_rh_wl    = rh_wl_q;
  assign i2c_bit_ctrl = (ADDR16 != 0);
  assign i2c_data     = i2c_data_q;
  assign busy         = busy_q;
  assign init_done    = done_q;
  assign init_err     = err_q;
  assign err_idx      = err_idx_q;

endmodule

`default_nettype wire
